// File: rtl/pool_scan_sequencer.sv
// pool_scan_sequencer: raster-scans a zero-padded frame and times line-buffer shifts and pooling-window evaluations.
// Ports: clk, rst (sync, active-high); en (start/pause), data_valid (upstream pixel valid), pe_ready (PE can take a window);
// rd_en (pull one real pixel), is_padding (current position is border), buffer_en (shift element in),
// pe_en (complete window in buffer), done (one-cycle end-of-frame pulse).
module pool_scan_sequencer #(
  parameter int pINPUT_WIDTH  = 28,
  parameter int pINPUT_HEIGHT = 28,
  parameter int pKERNEL_SIZE  = 2,
  parameter int pPADDING      = 0,
  parameter int pSTRIDE       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data_valid,
  input  logic pe_ready,
  output logic rd_en,
  output logic is_padding,
  output logic buffer_en,
  output logic pe_en,
  output logic done
);
  localparam int W  = pINPUT_WIDTH;
  localparam int H  = pINPUT_HEIGHT;
  localparam int K  = pKERNEL_SIZE;
  localparam int P  = pPADDING;
  localparam int S  = pSTRIDE;
  localparam int PW = W + 2 * P;
  localparam int PH = H + 2 * P;
  localparam int CW = $clog2(PW + 1);
  localparam int RW = $clog2(PH + 1);
  localparam int SW = $clog2(S + 1);
  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
  state_t state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [SW-1:0] pc, pr;
  logic go, accept, c_last, r_last;
  always_comb begin
    c_last     = c == CW'(PW - 1);
    r_last     = r == RW'(PH - 1);
    // r+1 > P is r >= P written so that P=0 does not become a constant compare
    is_padding = state == SCAN && (!((r + RW'(1)) > RW'(P)) || r >= RW'(P + H) ||
                                   !((c + CW'(1)) > CW'(P)) || c >= CW'(P + W));
    go         = state == SCAN && en && pe_ready;
    rd_en      = go && !is_padding;
    accept     = go && (is_padding || data_valid);
    buffer_en  = accept;
    pe_en      = accept && (r + RW'(1)) >= RW'(K) && (c + CW'(1)) >= CW'(K) && pr == '0 && pc == '0;
    done       = state == FIN;
  end
  // Phases count stride steps since the first full window; they are forced to 0 on reaching K-1,
  // so values held before that point never matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      pr    <= '0;
      pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          r     <= '0;
          c     <= '0;
          pr    <= '0;
          pc    <= '0;
          state <= en ? SCAN : IDLE;
        end
        SCAN: if (accept) begin
          c  <= c_last ? '0 : c + CW'(1);
          pc <= (c_last || c + CW'(1) == CW'(K - 1) || pc == SW'(S - 1)) ? '0 : pc + SW'(1);
          if (c_last) begin
            r     <= r_last ? '0 : r + RW'(1);
            pr    <= (r_last || r + RW'(1) == RW'(K - 1) || pr == SW'(S - 1)) ? '0 : pr + SW'(1);
            state <= r_last ? FIN : SCAN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_scan_sequencer.sv
// tb_pool_scan_sequencer: vector table plus scoreboarded frames for two sequencer configurations.
module tb_pool_scan_sequencer;
  logic clk, rst, en, dv, pr, sel;
  logic rd0, pad0, be0, pe0, dn0, rd1, pad1, be1, pe1, dn1;
  logic o_rd, o_pad, o_be, o_pe, o_dn;
  int tests = 0, fails = 0;
  typedef struct packed {logic rst, en, dv, pr, rd, pad, be, pe, dn;} vec_t;
  typedef struct packed {logic pad, pe;} exp_t;
  vec_t tv[14];
  pool_scan_sequencer #(.pINPUT_WIDTH(4), .pINPUT_HEIGHT(4), .pKERNEL_SIZE(2), .pPADDING(0), .pSTRIDE(2)) u0 (
    .clk(clk), .rst(rst), .en(en && !sel), .data_valid(dv), .pe_ready(pr),
    .rd_en(rd0), .is_padding(pad0), .buffer_en(be0), .pe_en(pe0), .done(dn0));
  pool_scan_sequencer #(.pINPUT_WIDTH(4), .pINPUT_HEIGHT(4), .pKERNEL_SIZE(2), .pPADDING(1), .pSTRIDE(1)) u1 (
    .clk(clk), .rst(rst), .en(en && sel), .data_valid(dv), .pe_ready(pr),
    .rd_en(rd1), .is_padding(pad1), .buffer_en(be1), .pe_en(pe1), .done(dn1));
  assign o_rd  = sel ? rd1 : rd0;
  assign o_pad = sel ? pad1 : pad0;
  assign o_be  = sel ? be1 : be0;
  assign o_pe  = sel ? pe1 : pe0;
  assign o_dn  = sel ? dn1 : dn0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input logic s, input int dvm, input int stall_idx, input int e_acc, input int e_pad,
                           input int e_rd, input int e_pe, input int e_len, input int e_fpe, input logic keep);
    int w, h, k, st, p, acc, padc, rdc, pec, fpe, first_k, last_k, stall_left;
    logic done_bad, timed_out;
    exp_t q[$];
    exp_t e;
    w = 4; h = 4; k = 2; st = s ? 1 : 2; p = s ? 1 : 0;
    for (int rr = 0; rr < h + 2 * p; rr++)
      for (int cc = 0; cc < w + 2 * p; cc++) begin
        e.pad = rr < p || rr >= p + h || cc < p || cc >= p + w;
        e.pe  = rr >= k - 1 && cc >= k - 1 && (rr - (k - 1)) % st == 0 && (cc - (k - 1)) % st == 0;
        q.push_back(e);
      end
    sel = s; en = 1; acc = 0; padc = 0; rdc = 0; pec = 0; fpe = -1; first_k = -1; last_k = -1;
    stall_left = 5; done_bad = 0; timed_out = 1;
    for (int kk = 0; kk < 400; kk++) begin
      dv = dvm == 0 || kk % 2 == 0;
      pr = !(kk > 0 && acc == stall_idx && stall_left > 0);
      #1;
      if (!pr) begin
        chk("stall_rd_en", int'(o_rd), 0);
        chk("stall_buffer_en", int'(o_be), 0);
        stall_left--;
      end
      if ((o_rd || o_pad) && first_k < 0) first_k = kk;
      if (o_rd) rdc++;
      if (o_dn) done_bad = 1;
      if (o_pe) pec++;
      if (o_be) begin
        acc++;
        if (o_pad) padc++;
        if (o_pe && fpe < 0) fpe = acc;
        if (q.size() == 0) chk("extra_accept", acc, e_acc);
        else begin
          e = q.pop_front();
          chk("sb_is_padding", int'(o_pad), int'(e.pad));
          chk("sb_rd_en", int'(o_rd), int'(!e.pad));
          chk("sb_pe_en", int'(o_pe), int'(e.pe));
        end
      end
      tick;
      if (acc == e_acc && last_k < 0) begin
        last_k = kk;
        timed_out = 0;
        break;
      end
    end
    chk("frame_timeout", int'(timed_out), 0);
    en = keep;
    pr = 1;
    #1;
    chk("done_pulse", int'(o_dn), 1);
    chk("fin_rd_en", int'(o_rd), 0);
    chk("fin_buffer_en", int'(o_be), 0);
    tick;
    chk("accepts", acc, e_acc);
    chk("padding_accepts", padc, e_pad);
    chk("rd_en_cycles", rdc, e_rd);
    chk("pe_en_pulses", pec, e_pe);
    chk("frame_length", last_k - first_k + 1, e_len);
    chk("first_pe_accept", fpe, e_fpe);
    chk("first_scan_cycle", first_k, 1);
    chk("early_done", int'(done_bad), 0);
    chk("scoreboard_left", q.size(), 0);
  endtask
  initial begin
    int acc;
    logic hit;
    rst = 1; en = 0; dv = 0; pr = 1; sel = 0;
    repeat (2) tick;
    tv[0]  = 9'b1_1_1_1_0_0_0_0_0;
    tv[1]  = 9'b0_0_1_1_0_0_0_0_0;
    tv[2]  = 9'b0_1_1_1_0_0_0_0_0;
    tv[3]  = 9'b0_1_0_1_1_0_0_0_0;
    tv[4]  = 9'b0_0_1_1_0_0_0_0_0;
    tv[5]  = 9'b0_1_1_0_0_0_0_0_0;
    for (int i = 6; i < 11; i++) tv[i] = 9'b0_1_1_1_1_0_1_0_0;
    tv[11] = 9'b0_1_1_1_1_0_1_1_0;
    tv[12] = 9'b1_1_1_1_1_0_1_0_0;
    tv[13] = 9'b0_0_1_1_0_0_0_0_0;
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst; en = tv[i].en; dv = tv[i].dv; pr = tv[i].pr;
      #1;
      chk($sformatf("vec%0d_rd_en", i), int'(o_rd), int'(tv[i].rd));
      chk($sformatf("vec%0d_is_padding", i), int'(o_pad), int'(tv[i].pad));
      chk($sformatf("vec%0d_buffer_en", i), int'(o_be), int'(tv[i].be));
      chk($sformatf("vec%0d_pe_en", i), int'(o_pe), int'(tv[i].pe));
      chk($sformatf("vec%0d_done", i), int'(o_dn), int'(tv[i].dn));
      tick;
    end
    rst = 0; en = 0;
    run_frame(0, 0, -1, 16, 0, 16, 4, 16, 6, 0);
    run_frame(0, 1, -1, 16, 0, 32, 4, 32, 6, 0);
    run_frame(0, 0, 4, 16, 0, 16, 4, 21, 6, 0);
    sel = 0; en = 1; dv = 1; pr = 1; acc = 0; hit = 0;
    for (int kk = 0; kk < 100; kk++) begin
      #1;
      if (o_be) acc++;
      if (acc == 9) begin
        hit = 1;
        break;
      end
      tick;
    end
    chk("reset_test_reach_accept9", int'(hit), 1);
    rst = 1; en = 0;
    tick;
    rst = 0;
    #1;
    chk("rst_rd_en", int'(o_rd), 0);
    chk("rst_is_padding", int'(o_pad), 0);
    chk("rst_buffer_en", int'(o_be), 0);
    chk("rst_pe_en", int'(o_pe), 0);
    chk("rst_done", int'(o_dn), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      #1;
      chk("post_rst_done", int'(o_dn), 0);
      chk("post_rst_rd_en", int'(o_rd), 0);
    end
    tick;
    run_frame(0, 0, -1, 16, 0, 16, 4, 16, 6, 0);
    run_frame(0, 0, -1, 16, 0, 16, 4, 16, 6, 1);
    run_frame(0, 0, -1, 16, 0, 16, 4, 16, 6, 0);
    run_frame(1, 0, -1, 36, 20, 16, 25, 36, 8, 0);
    run_frame(1, 0, 0, 36, 20, 16, 25, 41, 8, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_scan_sequencer.md
POOL_SCAN_SEQUENCER -- requirements
Module: pool_scan_sequencer

Interface
REQ-001 Parameter pINPUT_WIDTH, default 28: unpadded frame width, in pixels.
REQ-002 Parameter pINPUT_HEIGHT, default 28: unpadded frame height, in pixels.
REQ-003 Parameter pKERNEL_SIZE, default 2: square window edge K.
REQ-004 Parameter pPADDING, default 0: zero border P added on every side.
REQ-005 Parameter pSTRIDE, default 1: window step S, applied both horizontally and vertically.
REQ-006 clk  input  1: clock, rising edge.
REQ-007 rst  input  1: reset, synchronous, active-high.
REQ-008 en  input  1: run enable; starts a frame from IDLE and pauses scanning while low.
REQ-009 data_valid  input  1: the upstream pixel presented this cycle is valid.
REQ-010 pe_ready  input  1: the pooling PE can accept a window; scanning stalls while low.
REQ-011 rd_en  output  1: request for one real pixel from upstream.
REQ-012 is_padding  output  1: the current scan position is border; the datapath substitutes zero.
REQ-013 buffer_en  output  1: shift the current element into the line buffer.
REQ-014 pe_en  output  1: the line buffer holds a complete output window; the PE evaluates it.
REQ-015 done  output  1: one-cycle pulse at frame completion.

Function
REQ-016 Derived constants SHALL be PW=W+2P, PH=H+2P, OW=(PW-K)/S+1, OH=(PH-K)/S+1; all counters SHALL be sized with $clog2 of their maximum value plus 1.
REQ-017 FSM states SHALL be IDLE, SCAN and FIN; IDLE->SCAN when en=1; SCAN->FIN on acceptance of position (PH-1,PW-1); FIN->IDLE unconditionally after one cycle.
REQ-018 SCAN SHALL visit positions (r,c) in raster order, with c in 0..PW-1 innermost and r in 0..PH-1; entering SCAN clears r and c to 0.
REQ-019 is_padding SHALL be 1 in SCAN when r<P, r>=P+H, c<P or c>=P+W, and 0 otherwise; it SHALL be 0 outside SCAN.
REQ-020 go SHALL be defined as state==SCAN && en && pe_ready.
REQ-021 rd_en SHALL be the combinational value go && !is_padding.
REQ-022 accept SHALL be go && (is_padding || data_valid): a padding position is accepted in one cycle, and a real position waits for data_valid.
REQ-023 buffer_en SHALL equal accept; c/r SHALL advance only on accept, with c wrapping to 0 and incrementing r at c==PW-1.
REQ-024 pe_en SHALL equal accept && r>=K-1 && c>=K-1 && row-phase==0 && col-phase==0.
REQ-025 The phase counters SHALL be mod-S counters cleared at r=K-1 and c=K-1 respectively; the implementation SHALL use no divider or modulo operator.
REQ-026 pe_en SHALL assert exactly OW*OH times per frame, and accept SHALL occur exactly PW*PH times per frame.
REQ-027 done SHALL be 1 only in FIN, i.e. the cycle after the final accept.
REQ-028 en=0 in SCAN SHALL hold all counters and force rd_en, buffer_en and pe_en to 0.
REQ-029 pe_ready=0 in SCAN SHALL produce the same hold as REQ-028, including at padding positions.
REQ-030 data_valid SHALL be ignored in IDLE and FIN.
REQ-031 en held at 1 through FIN SHALL start the next frame in the cycle after FIN.
REQ-032 The block SHALL be legal for K=1, P=0 and S>=K.
REQ-033 Frame sizes SHALL satisfy PW>=K and PH>=K; no other configuration is required.

Reset
REQ-034 rst=1 SHALL force state IDLE, r=c=0 and both phase counters to 0 at the next edge, regardless of state, including mid-scan.
REQ-035 During and after reset, rd_en, is_padding, buffer_en, pe_en and done SHALL be 0 until a new frame starts.
REQ-036 A frame interrupted by reset SHALL not be resumed and SHALL NOT produce done.

Verification
REQ-037 W=H=4, K=2, S=2, P=0; en=1, data_valid=1, pe_ready=1 -> 16 rd_en/accepts on consecutive cycles, pe_en on accepts #6, #8, #14 and #16 (1-based), done exactly 1 cycle after accept #16.
REQ-038 W=H=4, K=2, S=1, P=1 -> 36 accepts, 20 with is_padding=1 and rd_en=0, 16 rd_en, 25 pe_en pulses; the first pe_en is at position (1,1), accept #8.
REQ-039 Same as REQ-037 with data_valid low on every other cycle -> rd_en stays high while waiting, counts unchanged (16 accepts, 4 pe_en), frame length 32 cycles.
REQ-040 Same as REQ-037 with pe_ready=0 for 5 cycles at position (1,0) -> rd_en=buffer_en=0 for those 5 cycles, positions resume unchanged, totals unchanged.
REQ-041 rst=1 for one cycle after accept #9 of REQ-037 -> all outputs 0 the next cycle and no done; the following frame with en=1 reproduces the REQ-037 counts exactly.
REQ-042 en held at 1 across two back-to-back frames -> done pulses once per frame, and the second frame's first rd_en follows the cycle after the FIN cycle.
